// File: rtl/audio_peak_meter_pkg.sv
// Shared constants and helpers for the audio peak meter.
// Level width, default ballistics and the thermometer decode live here.
package audio_peak_meter_pkg;

    localparam int LEVEL_W           = 4;
    localparam int BAR_W             = 15;
    localparam int DEF_HOLD_SAMPLES  = 1024;
    localparam int DEF_DECAY_SHIFT   = 6;
    localparam int DEF_CLIP_HOLD     = 4096;

    // Folded magnitude of a signed word drops the sign bit.
    function automatic int mag_width(input int ws);
        return ws - 1;
    endfunction

    function automatic logic [BAR_W-1:0] therm(input logic [LEVEL_W-1:0] lvl);
        logic [BAR_W:0] ones;
        ones = ({{BAR_W{1'b0}}, 1'b1} << lvl) - {{BAR_W{1'b0}}, 1'b1};
        return ones[BAR_W-1:0];
    endfunction

endpackage

// File: rtl/audio_peak_meter_log2.sv
// uint15_log2: position of the highest set bit plus one, 0 for a zero input.
// Inputs are 15-bit magnitudes zero-extended to 16; bit 15 saturates at 15.
module uint15_log2
    import audio_peak_meter_pkg::*;
(
    input  logic [15:0]        value,
    output logic [LEVEL_W-1:0] log2
);

    always_comb begin
        log2 = '0;
        for (int unsigned i = 0; i < 15; i++) begin
            if (value[i]) log2 = LEVEL_W'(i + 1);
        end
        if (value[15]) log2 = '1;
    end

endmodule

// File: rtl/audio_peak_meter.sv
// Audio peak meter: one's-complement fold, hold-then-decay peak, log2 level and bar.
// Optional sticky clip indicator enabled by defining AUDIO_PEAK_METER_CLIP_EN.
module audio_peak_meter
    import audio_peak_meter_pkg::*;
#(
    parameter int ws           = 16,
    parameter int HOLD_SAMPLES = DEF_HOLD_SAMPLES,
    parameter int DECAY_SHIFT  = DEF_DECAY_SHIFT,
    parameter int CLIP_HOLD    = DEF_CLIP_HOLD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [ws-1:0]      in_sample,
    output logic               out_valid,
    output logic [LEVEL_W-1:0] level,
    output logic [BAR_W-1:0]   bar,
    output logic               clip
);

    localparam int MW = mag_width(ws);
    localparam int HW = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;

    logic               a_valid;
    logic [MW-1:0]      a_mag;
    logic [MW-1:0]      peak;
    logic [MW-1:0]      peak_next;
    logic [MW-1:0]      decay;
    logic [HW-1:0]      hold;
    logic [HW-1:0]      hold_next;
    logic [LEVEL_W-1:0] level_next;

    // Negative samples fold to ~x, so the most negative code maps to full scale.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_mag   <= '0;
        end else begin
            a_valid <= in_valid;
            if (in_valid) a_mag <= in_sample[ws-1] ? ~in_sample[MW-1:0] : in_sample[MW-1:0];
        end
    end

    always_comb begin
        decay = peak >> DECAY_SHIFT;
        if (decay == '0 && peak != '0) decay = MW'(1);
        peak_next = peak;
        hold_next = hold;
        if (a_mag >= peak) begin
            peak_next = a_mag;
            hold_next = HW'(HOLD_SAMPLES);
        end else if (hold != '0) begin
            hold_next = hold - HW'(1);
        end else begin
            peak_next = peak - decay;
        end
    end

    uint15_log2 u_log2 (
        .value (16'(peak_next)),
        .log2  (level_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            peak      <= '0;
            hold      <= '0;
            out_valid <= 1'b0;
            level     <= '0;
            bar       <= '0;
        end else begin
            out_valid <= a_valid;
            if (a_valid) begin
                peak  <= peak_next;
                hold  <= hold_next;
                level <= level_next;
                bar   <= therm(level_next);
            end
        end
    end

`ifdef AUDIO_PEAK_METER_CLIP_EN
    localparam int CW = (CLIP_HOLD > 0) ? $clog2(CLIP_HOLD + 1) : 1;

    logic          a_clip;
    logic [CW-1:0] clip_cnt;
    logic [CW-1:0] clip_cnt_next;

    always_comb begin
        clip_cnt_next = clip_cnt;
        if (a_clip)              clip_cnt_next = CW'(CLIP_HOLD);
        else if (clip_cnt != '0) clip_cnt_next = clip_cnt - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_clip   <= 1'b0;
            clip_cnt <= '0;
            clip     <= 1'b0;
        end else begin
            if (in_valid) begin
                a_clip <= (in_sample == {1'b0, {(ws-1){1'b1}}}) ||
                          (in_sample == {1'b1, {(ws-1){1'b0}}});
            end
            if (a_valid) begin
                clip_cnt <= clip_cnt_next;
                clip     <= (clip_cnt_next != '0);
            end
        end
    end
`else
    // Feature compiled out: clip reads constant 0 for any legal CLIP_HOLD.
    assign clip = (CLIP_HOLD < 0);
`endif

endmodule

// File: tb/tb_audio_peak_meter.sv
// Self-checking bench for audio_peak_meter: directed ballistics cases plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_audio_peak_meter;

    localparam int HOLD  = 4;
    localparam int DSH   = 3;
    localparam int CHOLD = 2;
`ifdef AUDIO_PEAK_METER_CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_sample = '0;
    logic        out_valid;
    logic [3:0]  level;
    logic [14:0] bar;
    logic        clip;

    int vectors = 0;
    int miscompares = 0;

    audio_peak_meter #(
        .ws           (16),
        .HOLD_SAMPLES (HOLD),
        .DECAY_SHIFT  (DSH),
        .CLIP_HOLD    (CHOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sample (in_sample),
        .out_valid (out_valid),
        .level     (level),
        .bar       (bar),
        .clip      (clip)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int lvl_of(input int p);
        int l = 0;
        while ((p >> l) != 0) l++;
        return l;
    endfunction

    // Reference model: peak/hold/clip as integers, outputs delayed two edges.
    int peak = 0, hold = 0, clipc = 0;
    bit s1v = 0, s1c = 0, ev = 0, ec = 0;
    int s1l = 0, el = 0;

    always @(posedge clk) begin
        int s, mag, d;
        if (rst) begin
            peak = 0; hold = 0; clipc = 0;
            s1v = 0; s1c = 0; s1l = 0;
            ev = 0; el = 0; ec = 0;
        end else begin
            ev = s1v;
            if (s1v) begin
                el = s1l;
                ec = s1c;
            end
            s1v = in_valid;
            if (in_valid) begin
                s = int'($signed(in_sample));
                mag = (s < 0) ? -s - 1 : s;
                if (mag >= peak) begin
                    peak = mag;
                    hold = HOLD;
                end else if (hold > 0) begin
                    hold--;
                end else begin
                    d = peak / (1 << DSH);
                    if (d == 0 && peak != 0) d = 1;
                    peak -= d;
                end
                s1l = lvl_of(peak);
                if (CLIP_ON && (s == 32767 || s == -32768)) clipc = CHOLD;
                else if (clipc > 0) clipc--;
                s1c = CLIP_ON && (clipc > 0);
            end
        end
    end

    always @(negedge clk) begin
        cmp("out_valid", out_valid, ev);
        cmp("level", level, el);
        cmp("bar", bar, (1 << el) - 1);
        cmp("clip", clip, ec);
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_chk(input logic [15:0] s, input int lvl, input bit clp);
        in_valid = 1'b1;
        in_sample = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        cmp("lit_valid", out_valid, 1);
        cmp("lit_level", level, lvl);
        cmp("lit_bar", bar, (1 << lvl) - 1);
        cmp("lit_clip", clip, clp);
        cmp("model_level", el, lvl);
    endtask

    initial begin
        int hold_lv[8]   = '{9, 9, 9, 9, 9, 8, 8, 8};
        int reload_lv[9] = '{9, 9, 9, 9, 9, 9, 9, 9, 8};
        int reload_s[9]  = '{256, 0, 0, 256, 0, 0, 0, 0, 0};
        int floor_lv[9]  = '{2, 2, 2, 2, 2, 2, 1, 0, 0};
        int floor_s[9]   = '{3, 0, 0, 0, 0, 0, 0, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cmp("rst_valid", out_valid, 0);
        cmp("rst_level", level, 0);
        cmp("rst_bar", bar, 0);
        cmp("rst_clip", clip, 0);

        send_chk(16'h4000, 15, 1'b0);

        do_reset();
        send_chk(16'hFFFF, 0, 1'b0);
        send_chk(16'h8000, 15, CLIP_ON);

        do_reset();
        send_chk(16'd256, hold_lv[0], 1'b0);
        for (int i = 1; i < 8; i++) send_chk(16'd0, hold_lv[i], 1'b0);

        do_reset();
        for (int i = 0; i < 9; i++) send_chk(16'(reload_s[i]), reload_lv[i], 1'b0);

        do_reset();
        for (int i = 0; i < 9; i++) send_chk(16'(floor_s[i]), floor_lv[i], 1'b0);

        // Sample sitting in stage A when reset lands is discarded.
        in_valid = 1'b1;
        in_sample = 16'h4000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cmp("flush_valid", out_valid, 0);
        cmp("flush_level", level, 0);
        cmp("flush_bar", bar, 0);
        @(posedge clk); #1;
        cmp("flush_valid2", out_valid, 0);

        // Reset beats a coincident strobe.
        rst = 1'b1;
        in_valid = 1'b1;
        in_sample = 16'h7FFF;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        cmp("coinc_valid", out_valid, 0);
        @(posedge clk); #1;
        cmp("coinc_valid2", out_valid, 0);
        cmp("coinc_level", level, 0);

`ifdef AUDIO_PEAK_METER_CLIP_EN
        do_reset();
        send_chk(16'h7FFF, 15, 1'b1);
        send_chk(16'h0000, 15, 1'b1);
        send_chk(16'h0000, 15, 1'b0);
`endif

        for (int n = 0; n < 3000; n++) begin
            int r;
            rst = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            case (r)
                0:       in_sample = 16'h7FFF;
                1:       in_sample = 16'h8000;
                2, 3, 4: in_sample = 16'h0000;
                5:       in_sample = 16'($signed($urandom_range(0, 63)) - 32);
                default: in_sample = 16'($urandom_range(0, 65535));
            endcase
            @(posedge clk); #1;
        end
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/audio_peak_meter.md
# audio_peak_meter

Per-channel audio level meter sitting directly downstream of the signed sample path. It folds each signed sample to a magnitude using the reduced-absolute rule (one's-complement fold). It tracks a peak with hold-then-decay ballistics and emits a 4-bit log2 level plus a 15-segment thermometer bar for LED/VU display. The log2 stage is the existing audio-peak log2 convention (log2+1, log2(0)=0).

## Interface
- `ws`, 16, sample word size (signed); magnitude width is ws-1
- `HOLD_SAMPLES`, 1024, accepted samples the peak is frozen after a new peak; 0 = no hold
- `DECAY_SHIFT`, 6, per-sample decay is peak >> DECAY_SHIFT (minimum 1 while peak != 0)
- `CLIP_HOLD`, 4096, accepted samples the clip flag stays asserted (only with clip feature)
- `clk`  in  1  sole clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  sample strobe, may be high every cycle
- `in_sample`  in  ws  signed two's-complement sample
- `out_valid`  out  1  one-cycle strobe, level/bar updated
- `level`  out  4  log2 code of current peak, 0..15
- `bar`  out  15  thermometer, bar = (1 << level) - 1
- `clip`  out  1  sticky clip indicator (0 when feature compiled out)

## Operation
- Stage A (on in_valid): mag = in_sample < 0 ? ~in_sample : in_sample; unsigned ws-1 bits. -32768 → 32767, -1 → 0.
- Stage B (on stage-A valid), peak register P (ws-1 bits), hold counter H (width $clog2(HOLD_SAMPLES+1)):
  - mag >= P: P <= mag, H <= HOLD_SAMPLES (equal value reloads hold).
  - else H != 0: H <= H - 1, P unchanged.
  - else: d = P >> DECAY_SHIFT; if d == 0 and P != 0 then d = 1; P <= P - d (never underflows, settles at 0).
- Level: highest set bit index of the updated P plus 1, 0 when P == 0; bar derived from level; both registered.
- No state machine beyond the pipeline; hold/decay is the two-mode counter above.
- Decay and hold advance only on accepted samples, never on idle cycles.

## Timing
- Latency: in_valid at edge N → stage A registered at N → out_valid, level, bar valid after edge N+1 (2-cycle latency, out_valid high for exactly one cycle per sample).
- Full throughput: back-to-back samples each produce an output; no stalls, no backpressure.
- Reset values: out_valid=0, level=0, bar=0, clip=0, P=0, H=0, pipeline valids=0.
- rst mid-stream: all state cleared on that edge; samples in flight are discarded (no out_valid for them); rst dominates a coincident in_valid.

## Configuration
- `AUDIO_PEAK_METER_CLIP_EN` defined: stage A flags clip when in_sample is 16'h7FFF or 16'h8000 (ws-generic: max or min); clip counter C loaded with CLIP_HOLD; C decrements on each non-clipping accepted sample; clip = (C != 0), registered and aligned with out_valid.
- Not defined: counter and compare logic absent, clip tied to 0.

## Structure
- Shared package: magnitude-width function (ws-1), level width (4), default HOLD_SAMPLES/DECAY_SHIFT/CLIP_HOLD constants, thermometer helper function.
- One sub-module: instantiate existing `uint15_log2` for the level computation (inputs zero-extended to 16 bits); abs fold and decay inline.

## Test plan
- Reset, then in_sample=16'h4000 single strobe → out_valid two cycles later, level=15, bar=15'h7FFF.
- in_sample=16'hFFFF (-1) after reset → level=0, bar=0; in_sample=16'h8000 → magnitude 32767, level=15.
- HOLD_SAMPLES=4, DECAY_SHIFT=3: sample 256 then zeros → level 9 (bar 15'h01FF) for peak + 4 zeros; 5th zero gives P=224, level=8; next P=196, 172.
- Equal-peak reload: HOLD=4, samples 256,0,0,256,0,0,0,0,0 → no decay until 5th zero after second 256.
- Decay floor: P=3, DECAY_SHIFT=3, zeros with HOLD=0 → P 2,1,0,0; level 2,1,0,0; no underflow.
- rst asserted with a sample in stage A → next cycle all outputs 0, no out_valid; with CLIP_EN: 16'h7FFF, CLIP_HOLD=2 → clip high, clears after 2 non-clip samples.
